keypad_scanner: RTL and testbench
=================================

Name: keypad_scanner

Overview:
- Parametrised matrix-keypad scanner; successor to the fixed 4x4 keypad block.
- Drives one-hot rows and samples active-high columns at a divided scan rate.
- Debounces both press and release over whole scan frames, and detects multi-key frames.
- Emits single-cycle press, release and optional auto-repeat events with a linear key index; downstream logic maps the index to a symbol.

Parameters:
- ROWS, 4, number of row lines driven.
- COLS, 4, number of column lines sampled.
- SCAN_DIV, 27000, clk cycles per row slot.
- DEBOUNCE, 3, consecutive identical frames required to accept a press or a release (>=1).
- REPEAT_EN, 0, 1 enables auto-repeat.
- REPEAT_DELAY, 50, held frames before the first repeat.
- REPEAT_RATE, 10, held frames between subsequent repeats.
- KW (localparam), $clog2(ROWS*COLS), key index width.

Ports:
- clk, in, 1, system clock.
- rst_n, in, 1, asynchronous active-low reset.
- columna, in, COLS, raw column inputs, active-high, asynchronous.
- fila, out, ROWS, one-hot row drive.
- key_code, out, KW, index of the last accepted key.
- key_valid, out, 1, 1-clk pulse on accepted press or repeat.
- key_repeat, out, 1, 1-clk pulse coincident with key_valid on repeats only.
- key_release, out, 1, 1-clk pulse on accepted release.
- keypad_pressed, out, 1, level: a key is held (PRESSED or RELEASE_WAIT).
- multi_key, out, 1, level: last completed frame saw more than one key.

Behaviour:
- Reset values: fila = one-hot bit ROWS-1, row index 0. All other outputs 0. All counters 0. State IDLE.
- columna passes through a 2-flop synchronizer before use.
- Tick: the divider counts 0..SCAN_DIV-1; tick is the cycle the count equals SCAN_DIV-1.
- Row r drives fila bit ROWS-1-r.
- On each tick:
  - Sample synchronized columns for the current row.
  - Advance the row index, wrapping ROWS-1 -> 0.
  - Column bit COLS-1-c corresponds to column c.
  - Index = r*COLS + c.
- Frame accumulator:
  - Counts hits per frame: 0, 1, or 2+ (saturating).
  - Records the index of the first hit.
  - Frame ends on the tick that samples row ROWS-1.
  - Frame result is evaluated in that same cycle; outputs update on the next clk.
  - The accumulator clears for the next frame.
- multi_key updates every frame end: 1 if hits >= 2, else 0.
- FSM, evaluated at frame end only:
  - IDLE:
    - Single hit: go to DEBOUNCE, cand = idx, cnt = 1.
    - If DEBOUNCE == 1: go directly to PRESSED with a press event.
  - DEBOUNCE:
    - Single hit with idx == cand: cnt++. When cnt reaches DEBOUNCE, go to PRESSED, key_code <= cand, pulse key_valid.
    - Any other result (none, different key, multi): go to IDLE, cnt = 0.
  - PRESSED:
    - Frame contains cand (alone or with others): stay; rep_cnt++.
    - With REPEAT_EN, a repeat fires when rep_cnt reaches REPEAT_DELAY, then every REPEAT_RATE frames. Each repeat pulses key_valid and key_repeat, with key_code unchanged.
    - Frame lacks cand: go to RELEASE_WAIT, rcnt = 1.
    - If DEBOUNCE == 1: release immediately.
  - RELEASE_WAIT:
    - Frame lacks cand: rcnt++. At DEBOUNCE, go to IDLE and pulse key_release; keypad_pressed falls on the same clk.
    - cand present again: go back to PRESSED; rep_cnt is kept.
- Other keys pressed while in PRESSED or RELEASE_WAIT never generate events; a new key needs a return to IDLE first.
- key_code holds its value after release until the next accepted press.
- Reset mid-operation: immediate return to reset values; no release pulse is emitted.
- Frame latency from a stable press to key_valid: DEBOUNCE frames, plus at most 1 partial frame, plus sync and 1 clk.

Test Plan (ROWS=4, COLS=4, SCAN_DIV=4, DEBOUNCE=3, frame = 16 clk):
- Reset: hold rst_n=0 -> fila=4'b1000, all outputs 0. After release, fila rotates 1000 -> 0100 -> 0010 -> 0001 every 4 clk.
- Hold row 1 / col 2 (columna=4'b0010 while fila=0100) for 4 frames -> single key_valid pulse, key_code=6, keypad_pressed=1. No further pulses while held (REPEAT_EN=0).
- Release the held key for 3 frames -> single key_release pulse. keypad_pressed=0. key_code stays 6.
- Bounce: key present 2 frames, absent 1, present 2 -> no key_valid. A 3-frame stable run then yields key_valid.
- Two keys (idx 0 and 5) pressed from IDLE -> multi_key=1, no key_valid. Drop key 5 -> key_valid with key_code=0 after 3 clean frames.
- REPEAT_EN=1, REPEAT_DELAY=4, REPEAT_RATE=2, key 15 held -> press at frame 3; repeat pulses (key_repeat=1) at held frames 4, 6, 8; rst_n asserted mid-hold -> no key_release.

Source files
------------

// File: rtl/keypad_scanner.sv
// Matrix keypad scanner: one-hot row drive, synchronized column sampling,
// frame-level debounce of press and release, multi-key detection, auto-repeat.
module keypad_scanner #(
  parameter int ROWS         = 4,
  parameter int COLS         = 4,
  parameter int SCAN_DIV     = 27000,
  parameter int DEBOUNCE     = 3,
  parameter int REPEAT_EN    = 0,
  parameter int REPEAT_DELAY = 50,
  parameter int REPEAT_RATE  = 10,
  localparam int KW          = $clog2(ROWS*COLS)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [COLS-1:0] columna,
  output logic [ROWS-1:0] fila,
  output logic [KW-1:0]   key_code,
  output logic            key_valid,
  output logic            key_repeat,
  output logic            key_release,
  output logic            keypad_pressed,
  output logic            multi_key
);

  localparam int RIW  = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int DW   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int CW   = $clog2(DEBOUNCE + 1);
  localparam int RM0  = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int RMAX = (RM0 > DEBOUNCE) ? RM0 : DEBOUNCE;
  localparam int PW   = $clog2(RMAX + 2);

  localparam logic [ROWS-1:0] TOP  = ROWS'(1) << (ROWS - 1);
  localparam logic [RIW-1:0]  LAST = RIW'(ROWS - 1);
  localparam logic [CW-1:0]   DB   = CW'(DEBOUNCE);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DEBOUNCE,
    S_PRESSED,
    S_RELEASE_WAIT
  } state_t;

  state_t state, state_n;

  logic [COLS-1:0] sync1, sync2;
  logic [DW-1:0]   div;
  logic [RIW-1:0]  row;
  logic            tick, frame_end;

  logic [1:0]    acc_hits, row_hits, f_hits;
  logic [2:0]    hit_sum;
  logic [KW-1:0] acc_idx, row_first, row_base, f_idx;
  logic          acc_cand, row_cand, f_cand;

  logic [KW-1:0] cand, cand_n, code_n;
  logic [CW-1:0] cnt, cnt_n, rcnt, rcnt_n;
  logic [PW-1:0] rep_cnt, rep_n;
  logic          phase, phase_n, press_now;
  logic          valid_n, repeat_n, release_n;

  assign tick      = (div == DW'(SCAN_DIV - 1));
  assign frame_end = tick && (row == LAST);
  assign fila      = TOP >> row;
  assign keypad_pressed = (state == S_PRESSED) || (state == S_RELEASE_WAIT);

  assign row_base = KW'(row) * KW'(COLS);

  // Scan order inside a row is ascending column, so the first hit is the lowest c.
  always_comb begin
    row_hits  = '0;
    row_first = '0;
    row_cand  = 1'b0;
    for (int c = 0; c < COLS; c++) begin
      if (sync2[COLS-1-c]) begin
        if (row_hits == 2'd0) row_first = KW'(c);
        if (row_hits != 2'd2) row_hits = row_hits + 2'd1;
        if (row_base + KW'(c) == cand) row_cand = 1'b1;
      end
    end
  end

  assign hit_sum = {1'b0, acc_hits} + {1'b0, row_hits};
  assign f_hits  = (hit_sum >= 3'd2) ? 2'd2 : hit_sum[1:0];
  assign f_idx   = (acc_hits == 2'd0) ? row_base + row_first : acc_idx;
  assign f_cand  = acc_cand | row_cand;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1    <= '0;
      sync2    <= '0;
      div      <= '0;
      row      <= '0;
      acc_hits <= '0;
      acc_idx  <= '0;
      acc_cand <= 1'b0;
    end else begin
      sync1 <= columna;
      sync2 <= sync1;
      if (tick) begin
        div <= '0;
        row <= (row == LAST) ? '0 : row + 1'b1;
        if (row == LAST) begin
          acc_hits <= '0;
          acc_idx  <= '0;
          acc_cand <= 1'b0;
        end else begin
          acc_hits <= f_hits;
          acc_idx  <= f_idx;
          acc_cand <= f_cand;
        end
      end else begin
        div <= div + 1'b1;
      end
    end
  end

  always_comb begin
    state_n   = state;
    cand_n    = cand;
    cnt_n     = cnt;
    rcnt_n    = rcnt;
    rep_n     = rep_cnt;
    phase_n   = phase;
    code_n    = key_code;
    valid_n   = 1'b0;
    repeat_n  = 1'b0;
    release_n = 1'b0;
    press_now = 1'b0;
    if (frame_end) begin
      unique case (state)
        S_IDLE: begin
          if (f_hits == 2'd1) begin
            cand_n  = f_idx;
            cnt_n   = CW'(1);
            state_n = S_DEBOUNCE;
            if (CW'(1) >= DB) press_now = 1'b1;
          end
        end
        S_DEBOUNCE: begin
          if (f_hits == 2'd1 && f_idx == cand) begin
            cnt_n = cnt + CW'(1);
            if (cnt_n >= DB) press_now = 1'b1;
          end else begin
            state_n = S_IDLE;
            cnt_n   = '0;
          end
        end
        S_PRESSED: begin
          if (f_cand) begin
            if (REPEAT_EN != 0) begin
              rep_n = rep_cnt + PW'(1);
              if ((!phase && rep_n >= PW'(REPEAT_DELAY)) ||
                  (phase && rep_n >= PW'(REPEAT_RATE))) begin
                rep_n    = '0;
                phase_n  = 1'b1;
                valid_n  = 1'b1;
                repeat_n = 1'b1;
              end
            end
          end else begin
            rcnt_n  = CW'(1);
            state_n = S_RELEASE_WAIT;
            if (CW'(1) >= DB) begin
              state_n   = S_IDLE;
              rcnt_n    = '0;
              release_n = 1'b1;
            end
          end
        end
        S_RELEASE_WAIT: begin
          if (f_cand) begin
            state_n = S_PRESSED;
            rcnt_n  = '0;
          end else begin
            rcnt_n = rcnt + CW'(1);
            if (rcnt_n >= DB) begin
              state_n   = S_IDLE;
              rcnt_n    = '0;
              release_n = 1'b1;
            end
          end
        end
        default: state_n = S_IDLE;
      endcase
    end
    // Held-frame count already includes the debounce frames at press time.
    if (press_now) begin
      state_n = S_PRESSED;
      code_n  = cand_n;
      valid_n = 1'b1;
      cnt_n   = '0;
      rep_n   = PW'(DEBOUNCE);
      phase_n = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      cand        <= '0;
      cnt         <= '0;
      rcnt        <= '0;
      rep_cnt     <= '0;
      phase       <= 1'b0;
      key_code    <= '0;
      key_valid   <= 1'b0;
      key_repeat  <= 1'b0;
      key_release <= 1'b0;
      multi_key   <= 1'b0;
    end else begin
      state       <= state_n;
      cand        <= cand_n;
      cnt         <= cnt_n;
      rcnt        <= rcnt_n;
      rep_cnt     <= rep_n;
      phase       <= phase_n;
      key_code    <= code_n;
      key_valid   <= valid_n;
      key_repeat  <= repeat_n;
      key_release <= release_n;
      if (frame_end) multi_key <= (f_hits == 2'd2);
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: a 4x4 key-matrix model drives two instances,
// one without and one with auto-repeat.
module tb_keypad_scanner;

  logic       clk;
  logic       rst0, rst1;
  logic [15:0] keys0, keys1;
  logic [3:0] col0, col1, fila0, fila1;
  logic [3:0] code0, code1;
  logic       valid0, rep0, rel0, pr0, mk0;
  logic       valid1, rep1, rel1, pr1, mk1;

  int passed = 0;
  int total  = 0;
  int nv0 = 0, nr0 = 0, nrep0 = 0, nr1 = 0, nrep_lone1 = 0;
  int cyc = 0;
  int vq[$];
  int rq[$];

  keypad_scanner #(
    .ROWS(4), .COLS(4), .SCAN_DIV(4), .DEBOUNCE(3), .REPEAT_EN(0)
  ) dut0 (
    .clk(clk), .rst_n(rst0), .columna(col0), .fila(fila0),
    .key_code(code0), .key_valid(valid0), .key_repeat(rep0),
    .key_release(rel0), .keypad_pressed(pr0), .multi_key(mk0)
  );

  keypad_scanner #(
    .ROWS(4), .COLS(4), .SCAN_DIV(4), .DEBOUNCE(3), .REPEAT_EN(1),
    .REPEAT_DELAY(4), .REPEAT_RATE(2)
  ) dut1 (
    .clk(clk), .rst_n(rst1), .columna(col1), .fila(fila1),
    .key_code(code1), .key_valid(valid1), .key_repeat(rep1),
    .key_release(rel1), .keypad_pressed(pr1), .multi_key(mk1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Key k = r*4 + c connects row line fila[3-r] to column line columna[3-c].
  always_comb begin
    col0 = '0;
    col1 = '0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        if (keys0[r*4+c] && fila0[3-r]) col0[3-c] = 1'b1;
        if (keys1[r*4+c] && fila1[3-r]) col1[3-c] = 1'b1;
      end
  end

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (valid0) nv0++;
    if (rel0) nr0++;
    if (rep0) nrep0++;
    if (valid1) vq.push_back(cyc);
    if (rep1) rq.push_back(cyc);
    if (rep1 && !valid1) nrep_lone1++;
    if (rel1) nr1++;
  end

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic sync_frame();
    logic ok;
    logic [3:0] prevf;
    ok = 1'b0;
    prevf = fila0;
    for (int i = 0; i < 64 && !ok; i++) begin
      @(negedge clk);
      if (fila0 == 4'b1000 && prevf == 4'b0001) ok = 1'b1;
      prevf = fila0;
    end
    if (!ok) check("frame_sync_timeout", 0, 1);
  endtask

  typedef struct {
    logic [15:0] keys;
    int          frames;
    int          dv;
    int          dr;
    logic        pr;
    logic [3:0]  code;
    logic        mk;
  } vec_t;

  localparam int NV = 17;
  vec_t tbl[NV];
  int exp_v[4];
  int exp_r[3];
  int s0, v0, r0;
  logic [3:0] expf;

  initial begin
    tbl[0]  = '{16'h0040, 4, 1, 0, 1'b1, 4'd6, 1'b0};
    tbl[1]  = '{16'h0000, 3, 0, 1, 1'b0, 4'd6, 1'b0};
    tbl[2]  = '{16'h0040, 2, 0, 0, 1'b0, 4'd6, 1'b0};
    tbl[3]  = '{16'h0000, 1, 0, 0, 1'b0, 4'd6, 1'b0};
    tbl[4]  = '{16'h0040, 2, 0, 0, 1'b0, 4'd6, 1'b0};
    tbl[5]  = '{16'h0040, 1, 1, 0, 1'b1, 4'd6, 1'b0};
    tbl[6]  = '{16'h0000, 3, 0, 1, 1'b0, 4'd6, 1'b0};
    tbl[7]  = '{16'h0021, 3, 0, 0, 1'b0, 4'd6, 1'b1};
    tbl[8]  = '{16'h0001, 3, 1, 0, 1'b1, 4'd0, 1'b0};
    tbl[9]  = '{16'h0201, 2, 0, 0, 1'b1, 4'd0, 1'b1};
    tbl[10] = '{16'h0200, 3, 0, 1, 1'b0, 4'd0, 1'b0};
    tbl[11] = '{16'h0200, 3, 1, 0, 1'b1, 4'd9, 1'b0};
    tbl[12] = '{16'h0000, 2, 0, 0, 1'b1, 4'd9, 1'b0};
    tbl[13] = '{16'h0200, 1, 0, 0, 1'b1, 4'd9, 1'b0};
    tbl[14] = '{16'h0000, 3, 0, 1, 1'b0, 4'd9, 1'b0};
    tbl[15] = '{16'h0040, 6, 1, 0, 1'b1, 4'd6, 1'b0};
    tbl[16] = '{16'h0000, 3, 0, 1, 1'b0, 4'd6, 1'b0};
    exp_v = '{3, 4, 6, 8};
    exp_r = '{4, 6, 8};

    rst0 = 1'b0;
    rst1 = 1'b0;
    keys0 = '0;
    keys1 = '0;
    repeat (3) @(negedge clk);
    check("rst_fila", int'(fila0), 4'b1000);
    check("rst_code", int'(code0), 0);
    check("rst_valid", int'(valid0), 0);
    check("rst_repeat", int'(rep0), 0);
    check("rst_release", int'(rel0), 0);
    check("rst_pressed", int'(pr0), 0);
    check("rst_multi", int'(mk0), 0);
    check("rst_fila1", int'(fila1), 4'b1000);

    rst0 = 1'b1;
    rst1 = 1'b1;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (i == 0 || i % 4 == 3) begin
        expf = 4'b1000 >> (((i + 1) / 4) % 4);
        check($sformatf("rotate_%0d", i), int'(fila0), int'(expf));
      end
    end

    sync_frame();
    for (int p = 0; p < NV; p++) begin
      v0 = nv0;
      r0 = nr0;
      keys0 = tbl[p].keys;
      repeat (16 * tbl[p].frames) @(negedge clk);
      #1;
      check($sformatf("p%0d_valid_cnt", p), nv0 - v0, tbl[p].dv);
      check($sformatf("p%0d_release_cnt", p), nr0 - r0, tbl[p].dr);
      check($sformatf("p%0d_pressed", p), int'(pr0), int'(tbl[p].pr));
      check($sformatf("p%0d_code", p), int'(code0), int'(tbl[p].code));
      check($sformatf("p%0d_multi", p), int'(mk0), int'(tbl[p].mk));
    end
    check("no_repeat_dut0", nrep0, 0);

    sync_frame();
    vq.delete();
    rq.delete();
    keys1 = 16'h8000;
    s0 = cyc;
    repeat (16 * 9) @(negedge clk);
    #1;
    check("rep_code", int'(code1), 15);
    check("rep_pressed", int'(pr1), 1);
    check("rep_nvalid", vq.size(), 4);
    check("rep_nrepeat", rq.size(), 3);
    for (int i = 0; i < 4 && i < vq.size(); i++)
      check($sformatf("rep_valid_frame_%0d", i), (vq[i] - s0) / 16, exp_v[i]);
    for (int i = 0; i < 3 && i < rq.size(); i++)
      check($sformatf("rep_repeat_frame_%0d", i), (rq[i] - s0) / 16, exp_r[i]);
    check("rep_lone_repeat", nrep_lone1, 0);

    repeat (5) @(negedge clk);
    rst1 = 1'b0;
    #1;
    check("midrst_fila", int'(fila1), 4'b1000);
    check("midrst_pressed", int'(pr1), 0);
    check("midrst_code", int'(code1), 0);
    repeat (4) @(negedge clk);
    keys1 = '0;
    rst1 = 1'b1;
    repeat (40) @(negedge clk);
    #1;
    check("midrst_no_release", nr1, 0);
    check("midrst_pressed_after", int'(pr1), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
